// File: rtl/lms_pkg.sv
// Shared constants for the LMS host controller: geometry, command op codes,
// response status codes and FSM state encodings.
package lms_pkg;

  localparam int NTAPS = 4;
  localparam int W     = 16;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_TRAIN = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  localparam logic [2:0] ST_OK        = 3'b000;
  localparam logic [2:0] ST_ZERO_LEN  = 3'b001;
  localparam logic [2:0] ST_ABORT     = 3'b010;
  localparam logic [2:0] ST_CONVERGED = 3'b011;
  localparam logic [2:0] ST_BAD_OP    = 3'b100;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_TRAIN = 3'd2;
  localparam logic [2:0] S_SNAP  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

endpackage

// File: rtl/lms_conv_detect.sv
// Convergence detector: counts consecutive cycles with |err| < ERR_THRESH while
// active and pulses converged on the cycle the run reaches CONV_RUN.
module lms_conv_detect #(
  parameter int                  W          = lms_pkg::W,
  parameter logic signed [W-1:0] ERR_THRESH = 16'sd41,
  parameter int                  CONV_RUN   = 32
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                active,
  input  logic signed [W-1:0] err,
  output logic                converged
);

  localparam int RUN_W = $clog2(CONV_RUN + 1);

  logic [W:0]       mag;
  logic             below;
  logic [RUN_W-1:0] run;

  // One extra bit so that the most negative error maps to +2^(W-1), never below threshold.
  assign mag       = err[W-1] ? (~{err[W-1], err} + 1'b1) : {1'b0, err};
  assign below     = mag < {1'b0, ERR_THRESH};
  assign converged = active && below && (run == RUN_W'(CONV_RUN - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Rst || !active) run <= '0;
    else if (below)     run <= run + 1'b1;
    else                run <= '0;
  end

endmodule

// File: rtl/lms_host_ctrl.sv
// Host-side command controller for the 4-tap Q4.12 LMS core: LOAD / TRAIN / READ
// with a valid/ready response. Optional early stop on convergence: LMS_CONV_STOP_EN.
module lms_host_ctrl #(
  parameter int                  NTAPS      = lms_pkg::NTAPS,
  parameter int                  W          = lms_pkg::W,
  parameter int                  CNT_W      = 16,
  parameter logic signed [W-1:0] ERR_THRESH = 16'sd41,
  parameter int                  CONV_RUN   = 32
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [NTAPS*W-1:0]    cmd_data,
  input  logic                  abort,
  output logic [NTAPS*W-1:0]    w_set,
  output logic                  load_weights,
  output logic                  training_en,
  input  logic [NTAPS*W-1:0]    w_cur,
  input  logic signed [W-1:0]   err,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [NTAPS*W-1:0]    rsp_data,
  output logic [2:0]            rsp_status,
  output logic [CNT_W-1:0]      rsp_count
);

  import lms_pkg::*;

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] remaining;
  logic             accept, zero_len, last_cycle, converged;

  assign accept     = (state == S_IDLE) && cmd_valid;
  assign zero_len   = (cmd_data[CNT_W-1:0] == '0);
  assign last_cycle = (remaining == CNT_W'(1));

`ifdef LMS_CONV_STOP_EN
  lms_conv_detect #(
    .W          (W),
    .ERR_THRESH (ERR_THRESH),
    .CONV_RUN   (CONV_RUN)
  ) u_conv (
    .Clk       (Clk),
    .Rst       (Rst),
    .active    (state == S_TRAIN),
    .err       (err),
    .converged (converged)
  );
`else
  logic unused_conv;
  assign unused_conv = &{1'b0, err, ERR_THRESH, CONV_RUN[0], ST_CONVERGED};
  assign converged   = 1'b0;
`endif

  // NOTE: next state gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:
        if (cmd_valid) begin
          case (cmd_op)
            OP_LOAD:  state_nxt = S_LOAD;
            OP_TRAIN: state_nxt = zero_len ? S_RESP : S_TRAIN;
            OP_READ:  state_nxt = S_SNAP;
            default:  state_nxt = S_RESP;
          endcase
        end
      S_LOAD:  state_nxt = S_RESP;
      S_TRAIN: if (last_cycle || abort || converged) state_nxt = S_SNAP;
      S_SNAP:  state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake and strobe outputs are registered decodes of the next state.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state        <= S_IDLE;
      cmd_ready    <= 1'b1;
      load_weights <= 1'b0;
      training_en  <= 1'b0;
      rsp_valid    <= 1'b0;
      w_set        <= '0;
      remaining    <= '0;
      rsp_data     <= '0;
      rsp_status   <= ST_OK;
      rsp_count    <= '0;
    end else begin
      state        <= state_nxt;
      cmd_ready    <= (state_nxt == S_IDLE);
      load_weights <= (state_nxt == S_LOAD);
      training_en  <= (state_nxt == S_TRAIN);
      rsp_valid    <= (state_nxt == S_RESP);

      if (accept) begin
        rsp_count  <= '0;
        rsp_status <= ST_OK;
        case (cmd_op)
          OP_LOAD: begin
            w_set    <= cmd_data;
            rsp_data <= cmd_data;
          end
          OP_TRAIN: begin
            remaining <= cmd_data[CNT_W-1:0];
            if (zero_len) begin
              rsp_status <= ST_ZERO_LEN;
              rsp_data   <= w_cur;
            end
          end
          OP_READ: ;
          default: begin
            rsp_status <= ST_BAD_OP;
            rsp_data   <= '0;
          end
        endcase
      end

      // Count includes the exit cycle; status reflects the highest-priority exit cause.
      if (state == S_TRAIN) begin
        remaining <= remaining - 1'b1;
        rsp_count <= rsp_count + 1'b1;
        if (last_cycle)     rsp_status <= ST_OK;
        else if (abort)     rsp_status <= ST_ABORT;
        else if (converged) rsp_status <= ST_CONVERGED;
      end

      if (state == S_SNAP) rsp_data <= w_cur;
    end
  end

endmodule

// File: tb/tb_lms_host_ctrl.sv
// Directed bench for lms_host_ctrl with a simple behavioural core model
// (load on strobe, each tap i gains i+1 per training cycle).
module tb_lms_host_ctrl;

  localparam int NTAPS = 4;
  localparam int W     = 16;
  localparam int CNT_W = 16;
  localparam int DW    = NTAPS * W;

  logic                 Clk = 1'b0;
  logic                 Rst = 1'b1;
  logic                 cmd_valid = 1'b0;
  logic                 cmd_ready;
  logic [1:0]           cmd_op = 2'b00;
  logic [DW-1:0]        cmd_data = '0;
  logic                 abort = 1'b0;
  logic [DW-1:0]        w_set;
  logic                 load_weights;
  logic                 training_en;
  logic [DW-1:0]        w_cur;
  logic signed [W-1:0]  err = 16'sd1000;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic [DW-1:0]        rsp_data;
  logic [2:0]           rsp_status;
  logic [CNT_W-1:0]     rsp_count;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] core_w;

  lms_host_ctrl dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .abort        (abort),
    .w_set        (w_set),
    .load_weights (load_weights),
    .training_en  (training_en),
    .w_cur        (w_cur),
    .err          (err),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_status   (rsp_status),
    .rsp_count    (rsp_count)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (Rst) core_w <= '0;
    else if (load_weights) core_w <= w_set;
    else if (training_en)
      for (int i = 0; i < NTAPS; i++)
        core_w[i*W +: W] <= core_w[i*W +: W] + W'(i + 1);
  end
  assign w_cur = core_w;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [DW-1:0] data);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL send_ready: got %b expected 1", cmd_ready);
    end
    cmd_op = op; cmd_data = data; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0; cmd_data = '0;
  endtask

  task automatic test_reset;
    Rst = 1'b1;
    tick(); tick();
    checks++;
    if ({cmd_ready, load_weights, training_en, rsp_valid} !== 4'b1000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 1000", {cmd_ready, load_weights, training_en, rsp_valid});
    end
    checks++;
    if ({w_set, rsp_data, rsp_status, rsp_count} !== '0) begin
      errors++; $display("FAIL reset_data: got w_set=%h rsp_data=%h st=%b cnt=%0d expected all zero", w_set, rsp_data, rsp_status, rsp_count);
    end
    Rst = 1'b0;
    tick();
  endtask

  task automatic test_load;
    logic [DW-1:0] wl;
    wl = {16'h0000, 16'hF800, 16'h0800, 16'h1000};
    rsp_ready = 1'b0;
    send(2'b00, wl);
    checks++;
    if ({load_weights, rsp_valid} !== 2'b10) begin
      errors++; $display("FAIL load_strobe_t1: got lw,rv=%b expected 10", {load_weights, rsp_valid});
    end
    tick();
    checks++;
    if ({load_weights, rsp_valid} !== 2'b01) begin
      errors++; $display("FAIL load_rsp_t2: got lw,rv=%b expected 01", {load_weights, rsp_valid});
    end
    checks++;
    if (w_cur !== wl) begin
      errors++; $display("FAIL load_core_w: got %h expected %h", w_cur, wl);
    end
    checks++;
    if ({rsp_data, rsp_status, rsp_count} !== {wl, 3'b000, 16'd0} || w_set !== wl) begin
      errors++; $display("FAIL load_rsp: got data=%h st=%b cnt=%0d w_set=%h expected data=%h st=000 cnt=0", rsp_data, rsp_status, rsp_count, w_set, wl);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== wl) begin
      errors++; $display("FAIL load_hold: got rv=%b data=%h expected rv=1 data=%h", rsp_valid, rsp_data, wl);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      errors++; $display("FAIL load_done: got rdy,rv=%b expected 10", {cmd_ready, rsp_valid});
    end
  endtask

  // Runs a TRAIN command with rsp_ready high; response expected at T+count+2.
  task automatic run_train(input string name, input int n, input logic signed [W-1:0] e,
                           input logic [2:0] exp_st, input int exp_cnt,
                           input logic chk_data, input logic [DW-1:0] exp_data);
    int lat, en;
    lat = 0; en = 0;
    err = e;
    rsp_ready = 1'b1;
    send(2'b01, DW'(n));
    for (int k = 1; k <= 1200; k++) begin
      if (training_en) en++;
      if (rsp_valid) begin lat = k; break; end
      tick();
    end
    checks++;
    if (lat !== exp_cnt + 2) begin
      errors++; $display("FAIL %s_latency: got %0d expected %0d (0 = no response)", name, lat, exp_cnt + 2);
    end
    checks++;
    if (rsp_status !== exp_st || rsp_count !== CNT_W'(exp_cnt)) begin
      errors++; $display("FAIL %s_status: got st=%b cnt=%0d expected st=%b cnt=%0d", name, rsp_status, rsp_count, exp_st, exp_cnt);
    end
    checks++;
    if (en !== exp_cnt) begin
      errors++; $display("FAIL %s_en_cycles: got %0d expected %0d", name, en, exp_cnt);
    end
    if (chk_data) begin
      checks++;
      if (rsp_data !== exp_data) begin
        errors++; $display("FAIL %s_data: got %h expected %h", name, rsp_data, exp_data);
      end
    end
    tick();
    rsp_ready = 1'b0;
    err = 16'sd1000;
  endtask

  task automatic test_train_n5;
    run_train("train5", 5, 16'sd1000, 3'b000, 5, 1'b1, {16'h0014, 16'hF80F, 16'h080A, 16'h1005});
  endtask

  task automatic test_abort;
    int en;
    en = 0;
    rsp_ready = 1'b1;
    send(2'b01, DW'(100));
    for (int k = 1; k <= 12; k++) begin
      if (training_en) en++;
      if (k == 10) abort = 1'b1;
      if (k == 11) begin
        checks++;
        if ({training_en, rsp_valid} !== 2'b00) begin
          errors++; $display("FAIL abort_en_low: got en,rv=%b expected 00", {training_en, rsp_valid});
        end
      end
      if (k == 12) begin
        checks++;
        if ({rsp_valid, rsp_status, rsp_count} !== {1'b1, 3'b010, 16'd10}) begin
          errors++; $display("FAIL abort_rsp: got rv=%b st=%b cnt=%0d expected rv=1 st=010 cnt=10", rsp_valid, rsp_status, rsp_count);
        end
        checks++;
        if (rsp_data !== {16'h003C, 16'hF82D, 16'h081E, 16'h100F}) begin
          errors++; $display("FAIL abort_data: got %h expected 003cf82d081e100f", rsp_data);
        end
      end
      tick();
      abort = 1'b0;
    end
    checks++;
    if (en !== 10) begin
      errors++; $display("FAIL abort_en_cycles: got %0d expected 10", en);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_zero_and_bad;
    rsp_ready = 1'b0;
    send(2'b01, {48'hABCD_0000_0000, 16'h0000});
    checks++;
    if ({rsp_valid, training_en, rsp_status, rsp_count} !== {2'b10, 3'b001, 16'd0}) begin
      errors++; $display("FAIL zero_len: got rv=%b en=%b st=%b cnt=%0d expected rv=1 en=0 st=001 cnt=0", rsp_valid, training_en, rsp_status, rsp_count);
    end
    checks++;
    if (rsp_data !== {16'h003C, 16'hF82D, 16'h081E, 16'h100F}) begin
      errors++; $display("FAIL zero_len_data: got %h expected 003cf82d081e100f", rsp_data);
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    send(2'b11, {4{16'h5A5A}});
    checks++;
    if ({rsp_valid, training_en, rsp_status, rsp_count} !== {2'b10, 3'b100, 16'd0} || rsp_data !== '0) begin
      errors++; $display("FAIL bad_op: got rv=%b en=%b st=%b cnt=%0d data=%h expected rv=1 en=0 st=100 cnt=0 data=0", rsp_valid, training_en, rsp_status, rsp_count, rsp_data);
    end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    rsp_ready = 1'b0;
    send(2'b10, '0);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL read_early: got rv=%b expected 0", rsp_valid);
    end
    tick();
    checks++;
    if ({rsp_valid, rsp_status, rsp_count} !== {1'b1, 3'b000, 16'd0} || rsp_data !== {16'h003C, 16'hF82D, 16'h081E, 16'h100F}) begin
      errors++; $display("FAIL read_rsp: got rv=%b st=%b cnt=%0d data=%h expected rv=1 st=000 cnt=0 data=003cf82d081e100f", rsp_valid, rsp_status, rsp_count, rsp_data);
    end
    rsp_ready = 1'b1;
    tick();
    send(2'b11, '0);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_rsp: got rv=%b expected 1", rsp_valid);
    end
    tick();
    checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      errors++; $display("FAIL b2b_ready: got rdy,rv=%b expected 10", {cmd_ready, rsp_valid});
    end
    send(2'b11, '0);
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_convergence;
`ifdef LMS_CONV_STOP_EN
    run_train("conv10", 1000, 16'sd10, 3'b011, 32, 1'b0, '0);
    run_train("conv_neg40", 40, -16'sd40, 3'b011, 32, 1'b0, '0);
`else
    run_train("conv10", 1000, 16'sd10, 3'b000, 1000, 1'b0, '0);
    run_train("conv_neg40", 40, -16'sd40, 3'b000, 40, 1'b0, '0);
`endif
    run_train("conv_at_thresh", 40, 16'sd41, 3'b000, 40, 1'b0, '0);
    run_train("conv_most_neg", 40, -16'sd32768, 3'b000, 40, 1'b0, '0);
  endtask

  task automatic test_reset_mid_train;
    int seen;
    seen = 0;
    rsp_ready = 1'b1;
    send(2'b01, DW'(50));
    repeat (19) tick();
    checks++;
    if (training_en !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre: got en=%b expected 1", training_en);
    end
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    checks++;
    if ({cmd_ready, load_weights, training_en, rsp_valid} !== 4'b1000) begin
      errors++; $display("FAIL rst_mid_ctrl: got %b expected 1000", {cmd_ready, load_weights, training_en, rsp_valid});
    end
    checks++;
    if ({w_set, rsp_data, rsp_status, rsp_count} !== '0) begin
      errors++; $display("FAIL rst_mid_data: got w_set=%h data=%h st=%b cnt=%0d expected all zero", w_set, rsp_data, rsp_status, rsp_count);
    end
    for (int k = 0; k < 60; k++) begin
      if (rsp_valid || training_en) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL rst_mid_quiet: got %0d active cycles expected 0", seen);
    end
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_train_n5();
    test_abort();
    test_zero_and_bad();
    test_back_to_back();
    test_convergence();
    test_reset_mid_train();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
